// File: rtl/disp_ctrl.sv
// Display sequencer: runs one int_seg conversion per update request, latches the
// resulting segment frame and scans it onto a shared segment bus with one-hot digit enables.
module disp_ctrl #(
    parameter int SCAN_DIV     = 50000,
    parameter int CONV_TIMEOUT = 64,
    parameter bit BLANK_LZ     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] value,
    input  logic        value_err,
    input  logic        update,
    output logic        busy,
    output logic [13:0] conv_num,
    output logic        conv_start,
    output logic        conv_err,
    input  logic [31:0] conv_digits,
    input  logic        conv_done,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic        timeout
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int WW = $clog2(CONV_TIMEOUT + 1);
    localparam logic [31:0] DASH_FRAME = 32'h40404040;

    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_LATCH, S_ABORT} state_t;

    state_t         state_q, state_d;
    logic [13:0]    conv_num_q, conv_num_d;
    logic           err_q, err_d;
    logic [13:0]    pend_num_q, pend_num_d;
    logic           pend_err_q, pend_err_d;
    logic           pending_q, pending_d;
    logic [WW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0]    frame_q, frame_d;
    logic           frame_err_q, frame_err_d;
    logic           timeout_q, timeout_d;
    logic [SW-1:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]     idx_q, idx_d;
    logic           req_err;
    logic [3:0]     blank;

    assign req_err = value_err | (value > 14'd9999);

    always_comb begin
        state_d     = state_q;
        conv_num_d  = conv_num_q;
        err_d       = err_q;
        pend_num_d  = pend_num_q;
        pend_err_d  = pend_err_q;
        pending_d   = pending_q;
        wait_cnt_d  = wait_cnt_q;
        frame_d     = frame_q;
        frame_err_d = frame_err_q;
        timeout_d   = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (update) begin
                    state_d    = S_START;
                    conv_num_d = value;
                    err_d      = req_err;
                end
            end
            S_START: begin
                state_d    = S_WAIT;
                wait_cnt_d = '0;
            end
            S_WAIT: begin
                // Frame is taken on the done sample itself so it shows one cycle later.
                if (conv_done) begin
                    state_d     = S_LATCH;
                    frame_d     = conv_digits;
                    frame_err_d = err_q;
                    timeout_d   = 1'b0;
                end else if (wait_cnt_q == WW'(CONV_TIMEOUT - 1)) begin
                    state_d     = S_ABORT;
                    frame_d     = DASH_FRAME;
                    frame_err_d = 1'b1;
                    timeout_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            S_LATCH, S_ABORT: begin
                // A request arriving now is newer than the buffer, so it wins directly.
                if (update) begin
                    state_d    = S_START;
                    conv_num_d = value;
                    err_d      = req_err;
                    pending_d  = 1'b0;
                end else if (pending_q) begin
                    state_d    = S_START;
                    conv_num_d = pend_num_q;
                    err_d      = pend_err_q;
                    pending_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (update && (state_q == S_START || state_q == S_WAIT)) begin
            pend_num_d = value;
            pend_err_d = req_err;
            pending_d  = 1'b1;
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + SW'(1);
        idx_d      = idx_q;
        if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            conv_num_q  <= '0;
            err_q       <= 1'b0;
            pend_num_q  <= '0;
            pend_err_q  <= 1'b0;
            pending_q   <= 1'b0;
            wait_cnt_q  <= '0;
            frame_q     <= '0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
            scan_cnt_q  <= '0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            conv_num_q  <= conv_num_d;
            err_q       <= err_d;
            pend_num_q  <= pend_num_d;
            pend_err_q  <= pend_err_d;
            pending_q   <= pending_d;
            wait_cnt_q  <= wait_cnt_d;
            frame_q     <= frame_d;
            frame_err_q <= frame_err_d;
            timeout_q   <= timeout_d;
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
        end
    end

    // A digit blanks only when it shows zero and everything above it is blank.
    assign blank[3] = BLANK_LZ && !frame_err_q && (frame_q[31:24] == 8'h3F);
    assign blank[0] = 1'b0;
    for (genvar gi = 2; gi >= 1; gi--) begin : g_blank
        assign blank[gi] = blank[gi+1] && (frame_q[8*gi +: 8] == 8'h3F);
    end

    assign seg        = blank[idx_q] ? 8'h00 : frame_q[{idx_q, 3'b000} +: 8];
    assign an         = 4'b0001 << idx_q;
    assign busy       = (state_q != S_IDLE) | pending_q;
    assign conv_num   = conv_num_q;
    assign conv_start = (state_q == S_START);
    assign conv_err   = (state_q == S_START) & err_q;
    assign timeout    = timeout_q;
endmodule

// File: tb/tb_disp_ctrl.sv
// Bench for disp_ctrl: converter model plus scoreboard of expected conversion launches,
// with directed checks of status outputs and the scanned display.
module tb_disp_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] value;
    logic        value_err;
    logic        update;
    logic        busy;
    logic [13:0] conv_num;
    logic        conv_start;
    logic        conv_err;
    logic [31:0] conv_digits;
    logic        conv_done;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        timeout;

    logic        model_en;
    int          model_lat;
    int          model_hold;
    logic [31:0] model_digits;
    logic [31:0] model_dig;
    logic        model_done;
    logic        force_done;
    logic [31:0] force_dig;

    typedef struct packed {
        logic [13:0] num;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign conv_done   = model_done | force_done;
    assign conv_digits = force_done ? force_dig : model_dig;

    disp_ctrl #(.SCAN_DIV(4), .CONV_TIMEOUT(20), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .value(value), .value_err(value_err), .update(update),
        .busy(busy), .conv_num(conv_num), .conv_start(conv_start), .conv_err(conv_err),
        .conv_digits(conv_digits), .conv_done(conv_done), .seg(seg), .an(an),
        .timeout(timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Converter model: answers each launch after model_lat cycles.
    initial begin
        model_done = 1'b0;
        model_dig  = '0;
        forever begin
            @(negedge clk);
            if (conv_start && model_en) begin
                repeat (model_lat - 1) @(negedge clk);
                model_dig  = model_digits;
                model_done = 1'b1;
                repeat (model_hold) @(negedge clk);
                model_done = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every launch must match the oldest expected request.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (conv_start) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_start: got conv_num %0d expected no launch", conv_num);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_conv_num", 32'(conv_num), 32'(e.num));
                    chk("sb_conv_err", 32'(conv_err), 32'(e.err));
                end
            end else if (conv_err) begin
                n_cmp++;
                n_fail++;
                $display("FAIL stray_conv_err: got conv_err=1 expected 0 without conv_start");
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_update(input logic [13:0] v, input logic e, input bit push,
                             input logic exp_err, input bit chk_lat);
        value     = v;
        value_err = e;
        update    = 1'b1;
        if (push) exp_q.push_back({v, exp_err});
        @(negedge clk);
        update = 1'b0;
        if (chk_lat) begin
            chk("start_latency", 32'(conv_start), 32'd1);
            chk("busy_high", 32'(busy), 32'd1);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: got busy=1 expected 0 within 300 cycles", name);
        end
    endtask

    task automatic check_scan(input string name, input logic [31:0] exp_segs);
        logic [3:0] prev;
        int n = 0;
        prev = an;
        @(negedge clk);
        while (!(an == 4'b0001 && prev == 4'b1000) && n < 40) begin
            prev = an;
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_sync: got an=%b expected a 1000->0001 wrap", name, an);
        end else begin
            for (int d = 0; d < 4; d++) begin
                for (int c = 0; c < 4; c++) begin
                    chk({name, "_seg"}, 32'(seg), 32'(exp_segs[8*d +: 8]));
                    chk({name, "_an"}, 32'(an), 32'(4'b0001 << d));
                    @(negedge clk);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; value = '0; value_err = 1'b0; update = 1'b0;
        model_en = 1'b1; model_lat = 17; model_hold = 1; model_digits = '0;
        force_done = 1'b0; force_dig = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(conv_start), 32'd0);
        chk("rst_conv_num", 32'(conv_num), 32'd0);
        chk("rst_seg", 32'(seg), 32'h00);
        chk("rst_an", 32'(an), 32'b0001);
        chk("rst_timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 42 with leading-zero blanking
        model_lat = 17; model_digits = 32'h3F3F665B;
        do_update(14'd42, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_idle("t1_idle");
        chk("t1_timeout", 32'(timeout), 32'd0);
        check_scan("t1", 32'h00_00_66_5B);

        // error request, done held two cycles
        model_lat = 8; model_hold = 2; model_digits = 32'h763D507C;
        do_update(14'd5, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_idle("t2_idle");
        check_scan("t2", 32'h76_3D_50_7C);
        model_hold = 1;

        // out-of-range value; error frame with zero-looking upper bytes stays visible
        model_lat = 6; model_digits = 32'h3F3F5079;
        do_update(14'd12000, 1'b0, 1'b1, 1'b1, 1'b1);
        wait_idle("t3_idle");
        check_scan("t3", 32'h3F_3F_50_79);

        // update arriving in the LATCH cycle is not lost
        model_lat = 6; model_digits = 32'h3F3F3F4F;
        do_update(14'd300, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        do_update(14'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_idle("t3b_idle");
        check_scan("t3b", 32'h00_00_00_4F);

        // timeout: 20 WAIT cycles then abort
        model_en = 1'b0;
        do_update(14'd100, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        chk("t4_timeout_pre", 32'(timeout), 32'd0);
        @(negedge clk);
        chk("t4_timeout_set", 32'(timeout), 32'd1);
        chk("t4_busy_abort", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t4_busy_fall", 32'(busy), 32'd0);
        check_scan("t4", 32'h40_40_40_40);
        model_en = 1'b1; model_lat = 5; model_digits = 32'h3F3F665B;
        do_update(14'd42, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_idle("t4b_idle");
        chk("t4_timeout_clr", 32'(timeout), 32'd0);

        // requests during WAIT: last one wins
        model_lat = 10; model_digits = 32'h3F3F3F6F;
        do_update(14'd7, 1'b0, 1'b1, 1'b0, 1'b1);
        do_update(14'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        do_update(14'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_idle("t5_idle");
        force_dig = 32'h06060606; force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_late_busy", 32'(busy), 32'd0);
        check_scan("t5", 32'h00_00_00_6F);

        // reset mid-WAIT, converter answers afterwards
        do_update(14'd1234, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_start", 32'(conv_start), 32'd0);
        chk("t6_conv_num", 32'(conv_num), 32'd0);
        chk("t6_an", 32'(an), 32'b0001);
        chk("t6_seg", 32'(seg), 32'h00);
        chk("t6_timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("t6_busy_after", 32'(busy), 32'd0);
        check_scan("t6", 32'h00_00_00_00);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
